wb_arbiter_rr: RTL and testbench

//  Round-robin arbiter sharing one Wishbone slave bus among NUM_MASTERS Wishbone masters
//  (AXIS command bridge, debug/UART master, etc.). Grant is held for a master's whole CYC.
//  Bus-hang watchdog: a stalled slave gets an ERR back to the owning master, then the bus is freed.

---
 rtl/wb_arbiter_rr.sv | 178 +++++++++++++++++
 tb/tb_wb_arbiter_rr.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter sharing one Wishbone slave among NUM_MASTERS masters.
// Ownership is held for the whole CYC; a bus-hang watchdog errors out and frees a stalled bus.
module wb_arbiter_rr #(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WATCHDOG_CYCLES = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_MASTERS-1:0]                 m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                 m_stb_i,
  input  logic [NUM_MASTERS-1:0]                 m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      m_dat_i,
  input  logic [NUM_MASTERS*(DATA_WIDTH/8)-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]                  m_dat_o,
  output logic [NUM_MASTERS-1:0]                 m_ack_o,
  output logic [NUM_MASTERS-1:0]                 m_err_o,
  output logic                                   s_cyc_o,
  output logic                                   s_stb_o,
  output logic                                   s_we_o,
  output logic [ADDR_WIDTH-1:0]                  s_adr_o,
  output logic [DATA_WIDTH-1:0]                  s_dat_o,
  output logic [DATA_WIDTH/8-1:0]                s_sel_o,
  input  logic [DATA_WIDTH-1:0]                  s_dat_i,
  input  logic                                   s_ack_i,
  input  logic                                   s_err_i,
  output logic [NUM_MASTERS-1:0]                 grant_o,
  output logic                                   wdog_alert_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (WATCHDOG_CYCLES > 0) ? $clog2(WATCHDOG_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(WATCHDOG_CYCLES);
  localparam logic [CW-1:0] CNT_FIRE = CW'(WATCHDOG_CYCLES - 1);
  localparam bit WDOG_EN = (WATCHDOG_CYCLES > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WDOG,
    S_DRAIN
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic          g_cyc, g_stb, stall, rel;
  logic [IW:0]   pick_idle, pick_rel;

  // Returns {valid, index} of the first requester after 'last', wrapping; 'last' itself ranks lowest.
  function automatic logic [IW:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                          input logic [IW-1:0] last);
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_MASTERS;
      if (req[idx]) r = {1'b1, idx[IW-1:0]};
    end
    return r;
  endfunction

  assign g_cyc     = m_cyc_i[gidx_q];
  assign g_stb     = m_stb_i[gidx_q];
  assign pick_idle = rr_pick(m_cyc_i, last_q);
  assign pick_rel  = rr_pick(m_cyc_i, gidx_q);
  assign stall     = (state_q == S_GRANT) && g_cyc && g_stb && !s_ack_i && !s_err_i;
  assign rel       = ((state_q == S_GRANT) || (state_q == S_DRAIN)) && !g_cyc;

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_idle[IW]) begin
          state_d = S_GRANT;
          gidx_d  = pick_idle[IW-1:0];
          grant_d = '0;
          grant_d[pick_idle[IW-1:0]] = 1'b1;
          cnt_d   = '0;
        end
      end
      S_GRANT: begin
        if (stall) begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (WDOG_EN && (cnt_q == CNT_FIRE)) begin
            state_d = S_WDOG;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = '0;
        end
      end
      S_WDOG: begin
        state_d = S_DRAIN;
        cnt_d   = '0;
      end
      S_DRAIN: begin
        cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
    // Release of the owning master overrides everything: hand over directly, or go idle.
    if (rel) begin
      last_d = gidx_q;
      cnt_d  = '0;
      if (pick_rel[IW]) begin
        state_d = S_GRANT;
        gidx_d  = pick_rel[IW-1:0];
        grant_d = '0;
        grant_d[pick_rel[IW-1:0]] = 1'b1;
      end else begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    s_cyc_o      = 1'b0;
    s_stb_o      = 1'b0;
    s_we_o       = 1'b0;
    s_adr_o      = '0;
    s_dat_o      = '0;
    s_sel_o      = '0;
    m_ack_o      = '0;
    m_err_o      = '0;
    wdog_alert_o = 1'b0;
    if (state_q != S_IDLE) begin
      s_we_o  = m_we_i[gidx_q];
      s_adr_o = m_adr_i[int'(gidx_q)*ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o = m_dat_i[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
      s_sel_o = m_sel_i[int'(gidx_q)*SW +: SW];
    end
    case (state_q)
      S_GRANT: begin
        s_cyc_o = g_cyc;
        s_stb_o = g_cyc & g_stb;
        m_ack_o = grant_q & {NUM_MASTERS{s_ack_i}};
        m_err_o = grant_q & {NUM_MASTERS{s_err_i}};
      end
      S_WDOG: begin
        m_err_o      = grant_q;
        wdog_alert_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign grant_o = grant_q;
  assign m_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_arbiter_rr.sv
// Bench for wb_arbiter_rr: directed scenarios plus a randomized run against an ownership model.
module tb_wb_arbiter_rr;
  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = DW / 8;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack_o, m_err_o, grant_o;
  logic            s_cyc_o, s_stb_o, s_we_o, wdog_alert_o;
  logic [AW-1:0]   s_adr_o;
  logic [DW-1:0]   s_dat_o;
  logic [SW-1:0]   s_sel_o;
  logic [DW-1:0]   s_dat;
  logic            s_ack, s_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_arbiter_rr #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WATCHDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_sel_o(s_sel_o), .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant_o), .wdog_alert_o(wdog_alert_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  function automatic int rr_next(input logic [N-1:0] req, input int from);
    int i;
    for (int k = 1; k <= N; k++) begin
      i = (from + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    clear_inputs();
    m_cyc = '1; m_stb = '1; s_ack = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant_o); end
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL reset_scyc got=%b exp=0", s_cyc_o); end
    total++; if (m_ack_o !== 3'b000) begin bad++; $display("FAIL reset_ack got=%b exp=000", m_ack_o); end
    total++; if (m_err_o !== 3'b000) begin bad++; $display("FAIL reset_err got=%b exp=000", m_err_o); end
    total++; if (wdog_alert_o !== 1'b0) begin bad++; $display("FAIL reset_alert got=%b exp=0", wdog_alert_o); end
    step();
    total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL reset_hold_grant got=%b exp=000", grant_o); end
    do_reset();
    #2;
    total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL reset_idle_grant got=%b exp=000", grant_o); end
    total++; if (s_stb_o !== 1'b0) begin bad++; $display("FAIL reset_idle_stb got=%b exp=0", s_stb_o); end
  endtask

  task automatic test_single_read();
    m_cyc = 3'b001; m_stb = 3'b001; m_we = 3'b000; m_adr[0 +: AW] = 16'h1234; m_sel[0 +: SW] = 2'b11;
    #2;
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL single_latency_scyc got=%b exp=0", s_cyc_o); end
    step(); #2;
    total++; if (grant_o !== 3'b001) begin bad++; $display("FAIL single_grant got=%b exp=001", grant_o); end
    total++; if (s_cyc_o !== 1'b1) begin bad++; $display("FAIL single_scyc got=%b exp=1", s_cyc_o); end
    total++; if (s_stb_o !== 1'b1) begin bad++; $display("FAIL single_sstb got=%b exp=1", s_stb_o); end
    total++; if (s_adr_o !== 16'h1234) begin bad++; $display("FAIL single_adr got=%h exp=1234", s_adr_o); end
    total++; if (m_ack_o !== 3'b000) begin bad++; $display("FAIL single_noack got=%b exp=000", m_ack_o); end
    step(); step();
    s_ack = 1'b1; s_dat = 16'hBEEF; #2;
    total++; if (m_ack_o !== 3'b001) begin bad++; $display("FAIL single_ack got=%b exp=001", m_ack_o); end
    total++; if (m_dat_o !== 16'hBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=beef", m_dat_o); end
    step();
    s_ack = 1'b0; m_we = 3'b001; m_adr[0 +: AW] = 16'h5678; m_dat[0 +: DW] = 16'hA5A5; #2;
    total++; if (s_we_o !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", s_we_o); end
    total++; if (s_dat_o !== 16'hA5A5) begin bad++; $display("FAIL single_wdata got=%h exp=a5a5", s_dat_o); end
    step();
    s_ack = 1'b1; m_cyc = 3'b000; m_stb = 3'b000; #2;
    total++; if (m_ack_o !== 3'b001) begin bad++; $display("FAIL drop_with_ack got=%b exp=001", m_ack_o); end
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL drop_scyc got=%b exp=0", s_cyc_o); end
    step();
    s_ack = 1'b0; #2;
    total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL single_idle got=%b exp=000", grant_o); end
    clear_inputs();
  endtask

  task automatic test_stb_no_cyc();
    m_stb = '1; m_cyc = '0;
    step(); step(); #2;
    total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL stbnocyc_grant got=%b exp=000", grant_o); end
    total++; if (s_stb_o !== 1'b0) begin bad++; $display("FAIL stbnocyc_sstb got=%b exp=0", s_stb_o); end
    clear_inputs();
    step();
  endtask

  task automatic test_two_masters();
    do_reset();
    m_cyc = 3'b011; m_stb = 3'b011; m_adr[0 +: AW] = 16'h1000; m_adr[AW +: AW] = 16'h2000;
    step(); #2;
    total++; if (grant_o !== 3'b001) begin bad++; $display("FAIL two_first got=%b exp=001", grant_o); end
    total++; if (s_adr_o !== 16'h1000) begin bad++; $display("FAIL two_adr0 got=%h exp=1000", s_adr_o); end
    s_ack = 1'b1; #1;
    total++; if (m_ack_o !== 3'b001) begin bad++; $display("FAIL two_ack0 got=%b exp=001", m_ack_o); end
    step();
    s_ack = 1'b0; m_cyc = 3'b010; m_stb = 3'b010; #2;
    total++; if (grant_o !== 3'b001) begin bad++; $display("FAIL two_release_hold got=%b exp=001", grant_o); end
    step(); #2;
    total++; if (grant_o !== 3'b010) begin bad++; $display("FAIL two_handover got=%b exp=010", grant_o); end
    total++; if (s_cyc_o !== 1'b1) begin bad++; $display("FAIL two_nogap got=%b exp=1", s_cyc_o); end
    total++; if (s_adr_o !== 16'h2000) begin bad++; $display("FAIL two_adr1 got=%h exp=2000", s_adr_o); end
    s_ack = 1'b1; #1;
    total++; if (m_ack_o !== 3'b010) begin bad++; $display("FAIL two_ack1 got=%b exp=010", m_ack_o); end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp;
    do_reset();
    m_cyc = 3'b011; m_stb = 3'b011;
    step();
    for (int i = 0; i < 6; i++) begin
      exp = (i % 2 == 0) ? 3'b001 : 3'b010;
      #2;
      total++; if (grant_o !== exp) begin bad++; $display("FAIL b2b_grant txn=%0d got=%b exp=%b", i, grant_o, exp); end
      s_ack = 1'b1; #1;
      total++; if (m_ack_o !== exp) begin bad++; $display("FAIL b2b_ack txn=%0d got=%b exp=%b", i, m_ack_o, exp); end
      step();
      s_ack = 1'b0; m_cyc = 3'b011 & ~exp;
      step();
      m_cyc = 3'b011;
    end
    clear_inputs();
    step();
  endtask

  task automatic test_watchdog();
    do_reset();
    m_cyc = 3'b001; m_stb = 3'b001;
    step();
    m_cyc = 3'b011; m_stb = 3'b011;
    for (int k = 1; k <= WD; k++) begin
      #2;
      total++; if (wdog_alert_o !== 1'b0 || s_cyc_o !== 1'b1) begin
        bad++; $display("FAIL wdog_early stall=%0d alert=%b scyc=%b exp alert=0 scyc=1", k, wdog_alert_o, s_cyc_o);
      end
      total++; if (m_err_o !== 3'b000) begin bad++; $display("FAIL wdog_early_err stall=%0d got=%b exp=000", k, m_err_o); end
      step();
    end
    #2;
    total++; if (wdog_alert_o !== 1'b1) begin bad++; $display("FAIL wdog_alert got=%b exp=1", wdog_alert_o); end
    total++; if (m_err_o !== 3'b001) begin bad++; $display("FAIL wdog_err got=%b exp=001", m_err_o); end
    total++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin bad++; $display("FAIL wdog_bus cyc=%b stb=%b exp=0 0", s_cyc_o, s_stb_o); end
    step(); #2;
    total++; if (wdog_alert_o !== 1'b0) begin bad++; $display("FAIL drain_alert got=%b exp=0", wdog_alert_o); end
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL drain_scyc got=%b exp=0", s_cyc_o); end
    s_ack = 1'b1; s_err = 1'b1; #1;
    total++; if (m_ack_o !== 3'b000 || m_err_o !== 3'b000) begin bad++; $display("FAIL drain_late ack=%b err=%b exp=000 000", m_ack_o, m_err_o); end
    step();
    s_ack = 1'b0; s_err = 1'b0; m_cyc = 3'b010; m_stb = 3'b010; #2;
    total++; if (grant_o !== 3'b001) begin bad++; $display("FAIL drain_hold got=%b exp=001", grant_o); end
    step(); #2;
    total++; if (grant_o !== 3'b010) begin bad++; $display("FAIL drain_next got=%b exp=010", grant_o); end
    total++; if (s_cyc_o !== 1'b1) begin bad++; $display("FAIL drain_next_scyc got=%b exp=1", s_cyc_o); end
    clear_inputs();
    step();
  endtask

  task automatic test_async_reset();
    do_reset();
    m_cyc = 3'b010; m_stb = 3'b010;
    step(); step(); #2;
    total++; if (grant_o !== 3'b010) begin bad++; $display("FAIL areset_pre got=%b exp=010", grant_o); end
    s_ack = 1'b1; rst_n = 1'b0; #1;
    total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL areset_grant got=%b exp=000", grant_o); end
    total++; if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL areset_scyc got=%b exp=0", s_cyc_o); end
    total++; if (m_ack_o !== 3'b000 || m_err_o !== 3'b000) begin bad++; $display("FAIL areset_resp ack=%b err=%b exp=000 000", m_ack_o, m_err_o); end
    s_ack = 1'b0; m_cyc = 3'b011; m_stb = 3'b011;
    @(negedge clk);
    rst_n = 1'b1;
    step(); #2;
    total++; if (grant_o !== 3'b001) begin bad++; $display("FAIL areset_m0_first got=%b exp=001", grant_o); end
    clear_inputs();
    step();
  endtask

  task automatic test_random();
    int owner, last, stall, phase, ack_pct, fires;
    logic prev_ack;
    logic [N-1:0] eg, eack, eerr;
    logic escyc, estb, ealert;
    logic [AW-1:0] eadr;
    do_reset();
    owner = -1; last = N - 1; stall = 0; phase = 0; ack_pct = 50; prev_ack = 1'b0; fires = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) ack_pct = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(20, 70));
      for (int i = 0; i < N; i++) begin
        if (i == owner) begin
          m_cyc[i] = prev_ack ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 31) != 0);
          m_stb[i] = ($urandom_range(0, 15) != 0);
        end else begin
          m_cyc[i] = ($urandom_range(0, 2) == 0);
          m_stb[i] = ($urandom_range(0, 1) == 0);
        end
        m_we[i] = $urandom_range(0, 1) == 1;
        m_adr[i*AW +: AW] = AW'($urandom);
        m_dat[i*DW +: DW] = DW'($urandom);
        m_sel[i*SW +: SW] = SW'($urandom);
      end
      s_ack = ($urandom_range(0, 99) < ack_pct);
      s_err = ($urandom_range(0, 31) == 0);
      s_dat = DW'($urandom);
      #2;
      eg = '0; eack = '0; eerr = '0; eadr = '0;
      escyc = 1'b0; estb = 1'b0; ealert = (phase == 1);
      if (owner >= 0) begin
        eg[owner] = 1'b1;
        eadr = m_adr[owner*AW +: AW];
        if (phase == 0) begin
          escyc = m_cyc[owner];
          estb = m_cyc[owner] & m_stb[owner];
          eack[owner] = s_ack;
          eerr[owner] = s_err;
        end else if (phase == 1) begin
          eerr[owner] = 1'b1;
        end
      end
      total++; if (grant_o !== eg) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, grant_o, eg); end
      total++; if (s_cyc_o !== escyc) begin bad++; $display("FAIL rnd_scyc cyc=%0d got=%b exp=%b", c, s_cyc_o, escyc); end
      total++; if (s_stb_o !== estb) begin bad++; $display("FAIL rnd_sstb cyc=%0d got=%b exp=%b", c, s_stb_o, estb); end
      total++; if (m_ack_o !== eack) begin bad++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", c, m_ack_o, eack); end
      total++; if (m_err_o !== eerr) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, m_err_o, eerr); end
      total++; if (wdog_alert_o !== ealert) begin bad++; $display("FAIL rnd_alert cyc=%0d got=%b exp=%b", c, wdog_alert_o, ealert); end
      total++; if (s_adr_o !== eadr) begin bad++; $display("FAIL rnd_adr cyc=%0d got=%h exp=%h", c, s_adr_o, eadr); end
      total++; if (m_dat_o !== s_dat) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", c, m_dat_o, s_dat); end
      prev_ack = (owner >= 0) && (phase == 0) && s_ack;
      @(posedge clk);
      // Ownership rules: pick in rotation from the last owner; hold while CYC; watchdog then drain.
      if (owner < 0) begin
        owner = rr_next(m_cyc, last);
        phase = 0; stall = 0;
      end else if (phase == 1) begin
        phase = 2;
      end else if (!m_cyc[owner]) begin
        last = owner;
        owner = rr_next(m_cyc, last);
        phase = 0; stall = 0;
      end else if (phase == 0) begin
        if (m_stb[owner] && !s_ack && !s_err) begin
          stall++;
          if (stall == WD) begin phase = 1; stall = 0; fires++; end
        end else begin
          stall = 0;
        end
      end
      #1;
    end
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_stb_no_cyc();
    test_two_masters();
    test_back_to_back();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
